// File: rtl/udp_test_pkt_gen.sv
// udp_test_pkt_gen: UDP test-traffic sequencer for the app/ARP side of udp_ip_mac_top.
// Resolves the destination MAC through ARP with bounded retries, then emits bursts of
// payload packets once per period. Length, pattern and fill byte are taken per packet.
module udp_test_pkt_gen #(
    parameter int unsigned PAYLOAD_MAX = 1472,
    parameter int unsigned PERIOD_DEF  = 125_000_000,
    parameter int unsigned ARP_RETRY   = 3,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic        rgmii_clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [7:0]  fill_byte,
    input  logic [15:0] len_cfg,
    input  logic [31:0] period_cfg,
    input  logic [7:0]  burst_cfg,
    output logic        app_data_request,
    output logic [15:0] app_data_length,
    output logic        app_data_in_valid,
    output logic [7:0]  app_data_in,
    input  logic        udp_send_ack,
    output logic        arp_req,
    input  logic        arp_found,
    input  logic        mac_not_exist,
    input  logic        mac_send_end,
    output logic [31:0] pkt_count,
    output logic        arp_fail,
    output logic        busy
);

    localparam logic [15:0] LP_LEN_MAX    = 16'(PAYLOAD_MAX);
    localparam logic [31:0] LP_PERIOD_DEF = 32'(PERIOD_DEF);
    localparam logic [7:0]  LP_RETRY      = 8'(ARP_RETRY);

    typedef enum logic [3:0] {
        StIdle,
        StArpReq,
        StArpSend,
        StArpWait,
        StGenReq,
        StWrite,
        StSendWait,
        StGap,
        StCheckArp,
        StFail
    } state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic [31:0] r_timer;
    logic [31:0] r_period;
    logic [7:0]  r_retry;
    logic [7:0]  r_burst_idx;
    logic [15:0] r_len;
    logic [1:0]  r_mode;
    logic [7:0]  r_fill;
    logic [15:0] r_idx;
    logic [7:0]  r_lfsr;
    logic [31:0] r_pkt_count;

    logic        w_expire;
    logic        w_timer_clr;
    logic        w_enter_gen;
    logic        w_burst_more;
    logic [7:0]  w_burst_max;
    logic [15:0] w_len_clamped;
    logic [31:0] w_period_sel;
    logic [7:0]  w_lfsr_next;
    logic [7:0]  w_byte;

    // Derived config values and timer/LFSR helpers
    always_comb begin
        w_period_sel  = (period_cfg == 32'd0) ? LP_PERIOD_DEF : period_cfg;
        w_burst_max   = (burst_cfg == 8'd0) ? 8'd1 : burst_cfg;
        w_burst_more  = ({1'b0, r_burst_idx} + 9'd1) < {1'b0, w_burst_max};
        w_expire      = (r_timer == (r_period - 32'd1));
        // Fibonacci form of x^8+x^6+x^5+x^4+1, shifting towards the MSB
        w_lfsr_next   = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        if (len_cfg == 16'd0) begin
            w_len_clamped = 16'd1;
        end else if (len_cfg > LP_LEN_MAX) begin
            w_len_clamped = LP_LEN_MAX;
        end else begin
            w_len_clamped = len_cfg;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:     if (enable) w_state_d = StArpReq;
            StArpReq:   w_state_d = StArpSend;
            StArpSend:  if (mac_send_end) w_state_d = StArpWait;
            StArpWait: begin
                if (arp_found) begin
                    w_state_d = StGenReq;
                end else if (!enable) begin
                    w_state_d = StIdle;
                end else if (w_expire) begin
                    w_state_d = (r_retry >= LP_RETRY) ? StFail : StArpReq;
                end
            end
            StGenReq:   if (udp_send_ack) w_state_d = StWrite;
            StWrite:    if (r_idx == (r_len - 16'd1)) w_state_d = StSendWait;
            StSendWait: begin
                if (mac_send_end) begin
                    w_state_d = w_burst_more ? StGenReq : StGap;
                end else if (w_expire) begin
                    w_state_d = StCheckArp;
                end
            end
            StGap:      if (w_expire) w_state_d = StCheckArp;
            StCheckArp: begin
                if (!enable) begin
                    w_state_d = StIdle;
                end else if (mac_not_exist) begin
                    w_state_d = StArpReq;
                end else begin
                    w_state_d = StGenReq;
                end
            end
            StFail:     if (!enable) w_state_d = StIdle;
            default:    w_state_d = StIdle;
        endcase
    end

    // Entry strobes for the timed states and for packet setup
    always_comb begin
        w_timer_clr = (w_state_d != r_state) &&
                      ((w_state_d == StArpWait) || (w_state_d == StSendWait) ||
                       (w_state_d == StGap));
        w_enter_gen = (w_state_d == StGenReq) && (r_state != StGenReq);
    end

    // State, timer, counters and per-packet latches
    always_ff @(posedge rgmii_clk) begin
        if (!rstn) begin
            r_state     <= StIdle;
            r_timer     <= 32'd0;
            r_period    <= 32'd0;
            r_retry     <= 8'd0;
            r_burst_idx <= 8'd0;
            r_len       <= 16'd0;
            r_mode      <= 2'd0;
            r_fill      <= 8'd0;
            r_idx       <= 16'd0;
            r_lfsr      <= 8'd0;
            r_pkt_count <= 32'd0;
        end else begin
            r_state <= w_state_d;

            if (w_timer_clr) begin
                r_timer  <= 32'd0;
                r_period <= w_period_sel;
            end else begin
                r_timer <= r_timer + 32'd1;
            end

            if (r_state == StArpReq) begin
                r_retry <= r_retry + 8'd1;
            end else if ((r_state == StIdle) ||
                         ((r_state == StArpWait) && arp_found) ||
                         ((r_state == StCheckArp) && (w_state_d == StArpReq)) ||
                         ((r_state == StFail) && !enable)) begin
                r_retry <= 8'd0;
            end

            if ((r_state == StSendWait) && mac_send_end) begin
                r_burst_idx <= r_burst_idx + 8'd1;
                r_pkt_count <= r_pkt_count + 32'd1;
            end else if (((r_state == StArpWait) && arp_found) ||
                         ((r_state == StCheckArp) && (w_state_d == StGenReq))) begin
                r_burst_idx <= 8'd0;
            end

            if (w_enter_gen) begin
                r_len  <= w_len_clamped;
                r_mode <= mode;
                r_fill <= fill_byte;
                r_idx  <= 16'd0;
                r_lfsr <= LFSR_SEED;
            end else if (r_state == StWrite) begin
                r_idx  <= r_idx + 16'd1;
                r_lfsr <= w_lfsr_next;
            end
        end
    end

    // Payload byte for the current index
    always_comb begin
        w_byte = 8'd0;
        unique case (r_mode)
            2'd0: w_byte = r_idx[7:0];
            2'd1: begin
                if (r_idx < 16'd4) begin
                    unique case (r_idx[1:0])
                        2'd0:    w_byte = r_pkt_count[31:24];
                        2'd1:    w_byte = r_pkt_count[23:16];
                        2'd2:    w_byte = r_pkt_count[15:8];
                        default: w_byte = r_pkt_count[7:0];
                    endcase
                end else begin
                    w_byte = r_idx[7:0];
                end
            end
            2'd2:    w_byte = r_fill;
            default: w_byte = r_lfsr;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        app_data_request  = (r_state == StGenReq);
        app_data_in_valid = (r_state == StWrite);
        app_data_in       = (r_state == StWrite) ? w_byte : 8'd0;
        app_data_length   = r_len;
        arp_req           = (r_state == StArpReq);
        arp_fail          = (r_state == StFail);
        busy              = (r_state != StIdle) && (r_state != StFail);
        pkt_count         = r_pkt_count;
    end

endmodule

// File: tb/tb_udp_test_pkt_gen.sv
// tb_udp_test_pkt_gen: randomized scoreboard bench for udp_test_pkt_gen. A stack/ARP
// responder answers the DUT, sessions push expected packets, a monitor pops and compares.
module tb_udp_test_pkt_gen;

    localparam int unsigned PDEF = 150;

    logic        rgmii_clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [1:0]  mode;
    logic [7:0]  fill_byte;
    logic [15:0] len_cfg;
    logic [31:0] period_cfg;
    logic [7:0]  burst_cfg;
    logic        app_data_request;
    logic [15:0] app_data_length;
    logic        app_data_in_valid;
    logic [7:0]  app_data_in;
    logic        udp_send_ack;
    logic        arp_req;
    logic        arp_found;
    logic        mac_not_exist;
    logic        mac_send_end;
    logic [31:0] pkt_count;
    logic        arp_fail;
    logic        busy;

    logic        mse_arp;
    logic        mse_data;
    assign mac_send_end = mse_arp | mse_data;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          arp_cnt  = 0;
    int          arp_times[$];
    bit          resp_arp = 1'b1;
    int          arp_delay = 5;
    bit          mon_ignore = 1'b0;
    logic [31:0] model_cnt = 32'd0;

    int          exp_lens[$];
    logic [7:0]  exp_bytes[$];
    logic [7:0]  got_q[$];
    logic [15:0] got_len_out;

    udp_test_pkt_gen #(
        .PAYLOAD_MAX (1472),
        .PERIOD_DEF  (PDEF),
        .ARP_RETRY   (3),
        .LFSR_SEED   (8'hA5)
    ) dut (
        .rgmii_clk         (rgmii_clk),
        .rstn              (rstn),
        .enable            (enable),
        .mode              (mode),
        .fill_byte         (fill_byte),
        .len_cfg           (len_cfg),
        .period_cfg        (period_cfg),
        .burst_cfg         (burst_cfg),
        .app_data_request  (app_data_request),
        .app_data_length   (app_data_length),
        .app_data_in_valid (app_data_in_valid),
        .app_data_in       (app_data_in),
        .udp_send_ack      (udp_send_ack),
        .arp_req           (arp_req),
        .arp_found         (arp_found),
        .mac_not_exist     (mac_not_exist),
        .mac_send_end      (mac_send_end),
        .pkt_count         (pkt_count),
        .arp_fail          (arp_fail),
        .busy              (busy)
    );

    always #4 rgmii_clk = ~rgmii_clk;

    always @(posedge rgmii_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference LFSR step: x^8+x^6+x^5+x^4+1, new bit enters at the bottom
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        int v;
        int fb;
        v  = int'(s);
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return 8'(((v << 1) | fb) & 255);
    endfunction

    // Expected payload of one packet, from the pattern rules
    task automatic push_pkt(input int m, input logic [7:0] f, input int lcfg,
                            input logic [31:0] cnt);
        int         len;
        logic [7:0] s;
        logic [7:0] b;
        len = (lcfg == 0) ? 1 : ((lcfg > 1472) ? 1472 : lcfg);
        exp_lens.push_back(len);
        s = 8'hA5;
        for (int i = 0; i < len; i++) begin
            case (m)
                0:       b = 8'(i % 256);
                1:       b = (i < 4) ? 8'((cnt >> (8 * (3 - i))) & 32'hFF) : 8'(i % 256);
                2:       b = f;
                default: begin
                    b = s;
                    s = lfsr_step(s);
                end
            endcase
            exp_bytes.push_back(b);
        end
    endtask

    // Monitor: collect each valid run and compare it against the next expected packet
    initial begin : monitor
        int         elen;
        int         nbad;
        int         bad_idx;
        logic [7:0] bad_got;
        logic [7:0] bad_exp;
        logic [7:0] eb;
        forever begin
            @(negedge rgmii_clk);
            if (app_data_in_valid === 1'b1) begin
                if (got_q.size() == 0) got_len_out = app_data_length;
                got_q.push_back(app_data_in);
            end else if (got_q.size() != 0) begin
                if (mon_ignore) begin
                    got_q.delete();
                end else if (exp_lens.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pkt: got %0d bytes, required none", got_q.size());
                    got_q.delete();
                end else begin
                    elen = exp_lens.pop_front();
                    check("pkt_length_out", 32'(got_len_out), 32'(elen));
                    nbad    = 0;
                    bad_idx = 0;
                    bad_got = 8'h00;
                    bad_exp = 8'h00;
                    for (int i = 0; i < elen; i++) begin
                        eb = exp_bytes.pop_front();
                        if ((i >= got_q.size()) || (got_q[i] !== eb)) begin
                            if (nbad == 0) begin
                                bad_idx = i;
                                bad_exp = eb;
                                bad_got = (i < got_q.size()) ? got_q[i] : 8'hxx;
                            end
                            nbad++;
                        end
                    end
                    if (got_q.size() != elen) nbad++;
                    n_checks++;
                    if (nbad != 0) begin
                        n_fail++;
                        $display("FAIL pkt_payload: %0d bytes seen, %0d required; byte %0d got %02h required %02h",
                                 got_q.size(), elen, bad_idx, bad_got, bad_exp);
                    end
                    got_q.delete();
                end
            end
        end
    end

    // ARP side of the stack: frame-sent pulse after each request, then an optional reply
    initial begin : arp_resp
        mse_arp   = 1'b0;
        arp_found = 1'b0;
        forever begin
            @(negedge rgmii_clk);
            if (arp_req === 1'b1) begin
                @(negedge rgmii_clk);
                mse_arp = 1'b1;
                @(negedge rgmii_clk);
                mse_arp = 1'b0;
                if (resp_arp) begin
                    repeat (arp_delay) @(negedge rgmii_clk);
                    arp_found = 1'b1;
                    @(negedge rgmii_clk);
                    arp_found = 1'b0;
                end
            end
        end
    end

    // Count arp_req high cycles and when they occur
    initial begin : arp_mon
        forever begin
            @(negedge rgmii_clk);
            if (arp_req === 1'b1) begin
                arp_cnt++;
                arp_times.push_back(cyc);
            end
        end
    end

    // Data side of the stack: ack after a random delay, frame-sent after payload ends
    initial begin : data_resp
        int w;
        udp_send_ack = 1'b0;
        mse_data     = 1'b0;
        forever begin
            @(negedge rgmii_clk);
            if (app_data_request === 1'b1) begin
                repeat ($urandom_range(3, 0)) @(negedge rgmii_clk);
                udp_send_ack = 1'b1;
                @(negedge rgmii_clk);
                udp_send_ack = 1'b0;
                w = 0;
                while ((app_data_in_valid === 1'b1) && (w < 3000)) begin
                    @(negedge rgmii_clk);
                    w++;
                end
                repeat ($urandom_range(3, 0)) @(negedge rgmii_clk);
                mse_data = 1'b1;
                @(negedge rgmii_clk);
                mse_data = 1'b0;
            end
        end
    end

    // One enable session: ARP, `periods` bursts, then disable in the last gap
    task automatic run_session(input int m, input logic [7:0] f, input int lcfg, input int burst,
                               input int periods, input logic [31:0] per, input logic mne,
                               input bit mid_write_off);
        int b;
        int pe;
        int budget;
        int n;
        int a0;
        logic [31:0] target;
        mode          = 2'(m);
        fill_byte     = f;
        len_cfg       = 16'(lcfg);
        burst_cfg     = 8'(burst);
        period_cfg    = per;
        mac_not_exist = mne;
        arp_delay     = $urandom_range(10, 1);
        b  = (burst == 0) ? 1 : burst;
        pe = (per == 32'd0) ? PDEF : int'(per);
        for (int k = 0; k < b * periods; k++) begin
            push_pkt(m, f, lcfg, model_cnt);
            model_cnt++;
        end
        target = model_cnt;
        a0     = arp_cnt;
        budget = periods * (pe + 60) + b * periods * (((lcfg > 1472) ? 1472 : lcfg) + 20) + 200;
        enable = 1'b1;
        if (mid_write_off) begin
            n = 0;
            while ((app_data_in_valid !== 1'b1) && (n < 500)) begin
                @(negedge rgmii_clk);
                n++;
            end
            check("write_started", 32'(app_data_in_valid), 32'd1);
            repeat (10) @(negedge rgmii_clk);
            enable = 1'b0;
        end
        n = 0;
        while ((pkt_count !== target) && (n < budget)) begin
            @(negedge rgmii_clk);
            n++;
        end
        check("pkt_count", pkt_count, target);
        // first gap cycle: gap lasts P cycles, then one CHECK_ARP cycle, then IDLE
        enable = 1'b0;
        n = 0;
        while ((busy === 1'b1) && (n < pe + 100)) begin
            @(negedge rgmii_clk);
            n++;
        end
        check("gap_to_idle_cycles", 32'(n), 32'(pe + 1));
        check("arp_reqs_in_session", 32'(arp_cnt - a0), mne ? 32'(periods) : 32'd1);
        repeat (4) @(negedge rgmii_clk);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int a0;
        int t0;
        int tfail;
        rstn          = 1'b0;
        enable        = 1'b0;
        mode          = 2'd0;
        fill_byte     = 8'd0;
        len_cfg       = 16'd0;
        period_cfg    = 32'd0;
        burst_cfg     = 8'd0;
        mac_not_exist = 1'b0;
        repeat (3) @(negedge rgmii_clk);
        check("rst_arp_req", 32'(arp_req), 32'd0);
        check("rst_app_data_request", 32'(app_data_request), 32'd0);
        check("rst_valid", 32'(app_data_in_valid), 32'd0);
        check("rst_data", 32'(app_data_in), 32'd0);
        check("rst_length", 32'(app_data_length), 32'd0);
        check("rst_pkt_count", pkt_count, 32'd0);
        check("rst_arp_fail", 32'(arp_fail), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge rgmii_clk);

        // Basic mode-0 packet of 20 bytes
        run_session(0, 8'h00, 20, 1, 1, 32'd200, 1'b0, 1'b0);
        check("length_latched_20", 32'(app_data_length), 32'd20);

        // ARP never answered: three requests 1002 cycles apart, then FAIL
        resp_arp   = 1'b0;
        period_cfg = 32'd1000;
        a0 = arp_cnt;
        t0 = arp_times.size();
        enable = 1'b1;
        n = 0;
        while ((arp_fail !== 1'b1) && (n < 5000)) begin
            @(negedge rgmii_clk);
            n++;
        end
        tfail = cyc;
        check("arp_fail_set", 32'(arp_fail), 32'd1);
        check("busy_in_fail", 32'(busy), 32'd0);
        check("arp_req_count", 32'(arp_cnt - a0), 32'd3);
        if (arp_times.size() >= t0 + 3) begin
            check("arp_spacing_1", 32'(arp_times[t0 + 1] - arp_times[t0]), 32'd1002);
            check("arp_spacing_2", 32'(arp_times[t0 + 2] - arp_times[t0 + 1]), 32'd1002);
            check("fail_entry_delay", 32'(tfail - arp_times[t0 + 2]), 32'd1002);
        end
        repeat (20) @(negedge rgmii_clk);
        check("no_req_in_fail", 32'(arp_cnt - a0), 32'd3);
        enable = 1'b0;
        @(negedge rgmii_clk);
        check("arp_fail_cleared", 32'(arp_fail), 32'd0);
        check("idle_after_fail", 32'(busy), 32'd0);
        resp_arp = 1'b1;
        repeat (4) @(negedge rgmii_clk);

        // Mode 1 burst of three, length clamps, fill, LFSR over two periods
        run_session(1, 8'h00, 6, 3, 1, 32'd200, 1'b0, 1'b0);
        run_session(2, 8'h5A, 0, 1, 1, 32'd100, 1'b0, 1'b0);
        run_session(0, 8'h00, 2000, 1, 1, 32'd100, 1'b0, 1'b0);
        check("length_clamped_max", 32'(app_data_length), 32'd1472);
        run_session(2, 8'h5A, 30, 2, 1, 32'd100, 1'b0, 1'b0);
        run_session(3, 8'h00, 16, 2, 2, 32'd120, 1'b1, 1'b0);
        run_session(1, 8'h00, 3, 0, 2, 32'd0, 1'b0, 1'b0);

        // Randomized sessions
        for (int r = 0; r < 6; r++) begin
            run_session(int'($urandom_range(3, 0)), 8'($urandom), int'($urandom_range(40, 0)),
                        int'($urandom_range(3, 0)), int'($urandom_range(2, 1)),
                        ($urandom_range(3, 0) == 0) ? 32'd0 : 32'($urandom_range(150, 60)),
                        1'($urandom), 1'b0);
        end

        // Disable mid-WRITE: packet completes, IDLE after the gap
        run_session(0, 8'h00, 100, 1, 1, 32'd200, 1'b0, 1'b1);

        // Reset mid-WRITE aborts the packet on the next cycle
        mon_ignore = 1'b1;
        mode       = 2'd0;
        len_cfg    = 16'd200;
        burst_cfg  = 8'd1;
        period_cfg = 32'd200;
        enable     = 1'b1;
        n = 0;
        while ((app_data_in_valid !== 1'b1) && (n < 500)) begin
            @(negedge rgmii_clk);
            n++;
        end
        repeat (5) @(negedge rgmii_clk);
        rstn = 1'b0;
        @(negedge rgmii_clk);
        check("rst_mid_write_valid", 32'(app_data_in_valid), 32'd0);
        check("rst_mid_write_busy", 32'(busy), 32'd0);
        check("rst_mid_write_count", pkt_count, 32'd0);
        check("rst_mid_write_length", 32'(app_data_length), 32'd0);
        enable = 1'b0;
        repeat (8) @(negedge rgmii_clk);
        rstn       = 1'b1;
        model_cnt  = 32'd0;
        mon_ignore = 1'b0;
        repeat (2) @(negedge rgmii_clk);
        run_session(1, 8'h00, 8, 1, 1, 32'd80, 1'b0, 1'b0);

        repeat (10) @(negedge rgmii_clk);
        check("scoreboard_empty", 32'(exp_lens.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
